// File: rtl/uart_pkg.sv
// Shared constants, channel state type and divisor helper for the UART
// baud generator and its timers.
package uart_pkg;

    localparam int unsigned CLK_FRE_DEF = 50_000_000;
    localparam int unsigned BAUD_DEF    = 9600;
    localparam int unsigned OSR_DEF     = 16;
    localparam int unsigned DIV_W_DEF   = 16;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Clocks per bit, integer division. The result is kept 32 bits wide so
    // the caller can check that it fits its own divisor width before
    // narrowing it.
    function automatic logic [31:0] calc_div(input int unsigned clk_fre,
                                             input int unsigned baud);
        return 32'(clk_fre / baud);
    endfunction

endpackage

// File: rtl/uart_tick_cnt.sv
// Free-running period timer. Clear restarts the phase, enable lets it count,
// and tick is a one-cycle pulse on the last count of every period. Tick is
// combinational from the counter so the owner can register it together with
// anything else that must line up with it.
module uart_tick_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic         at_end;

    // '>=' rather than '==' so a counter that is somehow past the period
    // still wraps instead of running all the way round.
    assign at_end = (cnt >= (period - W'(1)));
    assign tick   = enable & ~clear & at_end;

    // Count clocks within the current period; restart on clear, idle or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Two-channel baud generator. The TX channel produces one strobe per bit
// period; the RX channel produces OSR oversample ticks per bit plus a
// mid-bit sample strobe. The clocks-per-bit divisor can be reloaded at
// runtime, but only while both channels are idle.
//
// Control inputs (div_load, tx_start/tx_done, rx_start/rx_done) are
// single-cycle requests with no back-pressure: each one is acted on at the
// edge that samples it. All outputs are single-cycle registered pulses.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FRE   = CLK_FRE_DEF,
    parameter int unsigned BAUD_RATE = BAUD_DEF,
    parameter int unsigned OSR       = OSR_DEF,
    parameter int unsigned DIV_W     = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_err,
    input  logic             tx_start,
    input  logic             tx_done,
    output logic             tx_bps_clk,
    input  logic             rx_start,
    input  logic             rx_done,
    output logic             rx_os_tick,
    output logic             rx_sample
);

    localparam int unsigned      OS_SH        = $clog2(OSR);
    localparam int unsigned      PH_W         = OS_SH;
    localparam logic [31:0]      RST_DIV_FULL = calc_div(CLK_FRE, BAUD_RATE);
    localparam logic [DIV_W-1:0] DIV_RST      = RST_DIV_FULL[DIV_W-1:0];
    localparam logic [DIV_W-1:0] OSR_MIN      = DIV_W'(OSR);
    localparam logic [PH_W-1:0]  PH_HALF      = PH_W'(OSR / 2);

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (64'(RST_DIV_FULL) >= (64'd1 << DIV_W)) begin : g_div_fit_err
            $error("uart_baud_gen: CLK_FRE/BAUD_RATE does not fit in DIV_W bits");
        end
        if ((OSR < 4) || ((OSR & (OSR - 1)) != 0)) begin : g_osr_err
            $error("uart_baud_gen: OSR must be a power of two and at least 4");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] os_div;
    ch_state_e        tx_state;
    ch_state_e        rx_state;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  ph_nxt;
    logic             load_ok;
    logic             tx_clear;
    logic             rx_clear;
    logic             tx_tick;
    logic             rx_tick;

    // A reload while a channel is running would corrupt the bit in flight,
    // and a divisor below OSR would leave the oversample timer with period 0.
    assign load_ok  = div_load && (tx_state == CH_IDLE) && (rx_state == CH_IDLE)
                      && (div_val >= OSR_MIN);

    // Start realigns the phase; done stops it. Done while idle is harmless.
    assign tx_clear = tx_start | tx_done;
    assign rx_clear = rx_start | rx_done;
    assign ph_nxt   = phase + PH_W'(1);

    // Divisor register with its oversample copy, and the reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DIV_RST;
            os_div  <= DIV_RST >> OS_SH;
            div_err <= 1'b0;
        end else begin
            div_err <= div_load & ~load_ok;
            if (load_ok) begin
                div_q  <= div_val;
                os_div <= div_val >> OS_SH;
            end
        end
    end

    uart_tick_cnt #(.W(DIV_W)) u_tx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tx_clear),
        .enable (tx_state == CH_RUN),
        .period (div_q),
        .tick   (tx_tick)
    );

    uart_tick_cnt #(.W(DIV_W)) u_rx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_clear),
        .enable (rx_state == CH_RUN),
        .period (os_div),
        .tick   (rx_tick)
    );

    // TX channel FSM and its registered bit strobe; start beats done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= CH_IDLE;
            tx_bps_clk <= 1'b0;
        end else begin
            tx_bps_clk <= tx_tick;
            case (tx_state)
                CH_IDLE: if (tx_start) tx_state <= CH_RUN;
                CH_RUN:  if (!tx_start && tx_done) tx_state <= CH_IDLE;
                default: tx_state <= CH_IDLE;
            endcase
        end
    end

    // RX channel FSM, oversample phase and the registered tick/sample pair.
    // The sample is decided from the phase the tick is about to produce, so
    // it lands on the same cycle as that tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= CH_IDLE;
            rx_os_tick <= 1'b0;
            rx_sample  <= 1'b0;
            phase      <= '0;
        end else begin
            rx_os_tick <= rx_tick;
            case (rx_state)
                CH_IDLE: if (rx_start) rx_state <= CH_RUN;
                CH_RUN:  if (!rx_start && rx_done) rx_state <= CH_IDLE;
                default: rx_state <= CH_IDLE;
            endcase
            if (rx_clear) begin
                phase     <= '0;
                rx_sample <= 1'b0;
            end else if (rx_tick) begin
                phase     <= ph_nxt;
                rx_sample <= (ph_nxt == PH_HALF);
            end else begin
                rx_sample <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen at its default parameters (50 MHz, 9600 baud,
// OSR 16). Each scenario pushes the cycle numbers at which strobes must
// appear; a monitor pops them as the DUT pulses.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_val = '0;
    logic        tx_start = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_done = 1'b0;
    logic        div_err;
    logic        tx_bps_clk;
    logic        rx_os_tick;
    logic        rx_sample;

    int total = 0;
    int bad = 0;
    logic [31:0] cyc = '0;

    // Expected cycle numbers of each output pulse.
    logic [31:0] tx_q[$];
    logic [31:0] tk_q[$];
    logic [31:0] sm_q[$];
    logic [31:0] er_q[$];

    uart_baud_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_load   (div_load),
        .div_val    (div_val),
        .div_err    (div_err),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .tx_bps_clk (tx_bps_clk),
        .rx_start   (rx_start),
        .rx_done    (rx_done),
        .rx_os_tick (rx_os_tick),
        .rx_sample  (rx_sample)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; a pulse set by edge k is seen
    // at the following falling edge with cyc == k.
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (tx_bps_clk) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_bps_clk: strobe at cyc=%0d, required none", cyc);
            end else if (tx_q[0] !== cyc) begin
                bad++;
                $display("FAIL tx_bps_clk: strobe at cyc=%0d, required cyc=%0d", cyc, tx_q[0]);
                void'(tx_q.pop_front());
            end else begin
                void'(tx_q.pop_front());
            end
        end
        if (rx_os_tick) begin
            total++;
            if (tk_q.size() == 0) begin
                bad++;
                $display("FAIL rx_os_tick: tick at cyc=%0d, required none", cyc);
            end else if (tk_q[0] !== cyc) begin
                bad++;
                $display("FAIL rx_os_tick: tick at cyc=%0d, required cyc=%0d", cyc, tk_q[0]);
                void'(tk_q.pop_front());
            end else begin
                void'(tk_q.pop_front());
            end
        end
        if (rx_sample) begin
            total++;
            if (sm_q.size() == 0) begin
                bad++;
                $display("FAIL rx_sample: sample at cyc=%0d, required none", cyc);
            end else if (sm_q[0] !== cyc) begin
                bad++;
                $display("FAIL rx_sample: sample at cyc=%0d, required cyc=%0d", cyc, sm_q[0]);
                void'(sm_q.pop_front());
            end else begin
                void'(sm_q.pop_front());
            end
        end
        if (div_err) begin
            total++;
            if (er_q.size() == 0) begin
                bad++;
                $display("FAIL div_err: pulse at cyc=%0d, required none", cyc);
            end else if (er_q[0] !== cyc) begin
                bad++;
                $display("FAIL div_err: pulse at cyc=%0d, required cyc=%0d", cyc, er_q[0]);
                void'(er_q.pop_front());
            end else begin
                void'(er_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go_until(input logic [31:0] t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present the given requests so that rising edge e samples them.
    task automatic drive_at(input logic [31:0] e, input logic ts, input logic td,
                            input logic rs, input logic rd, input logic dl,
                            input logic [15:0] dv);
        go_until(e - 32'd1);
        tx_start = ts;
        tx_done  = td;
        rx_start = rs;
        rx_done  = rd;
        div_load = dl;
        div_val  = dv;
        @(negedge clk);
        tx_start = 1'b0;
        tx_done  = 1'b0;
        rx_start = 1'b0;
        rx_done  = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [31:0] e;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_bps_clk, rx_os_tick, rx_sample, div_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required 0000",
                     {tx_bps_clk, rx_os_tick, rx_sample, div_err});
        end
        rst_n = 1'b1;
        @(negedge clk);
        // done requests while idle must not start anything
        e = cyc + 32'd2;
        drive_at(e, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        go_until(e + 32'd40);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL reset_idle_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // Reset divisor 50e6/9600 = 5208.
    task automatic test_default_div;
        logic [31:0] e0;
        e0 = cyc + 32'd2;
        tx_q.push_back(e0 + 32'd5208);
        tx_q.push_back(e0 + 32'd10416);
        drive_at(e0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_at(e0 + 32'd10420, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        go_until(e0 + 32'd10440);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL default_div_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // Smallest legal divisor (OSR = 16); done between strobes suppresses the next.
    task automatic test_load_tx;
        logic [31:0] e;
        logic [31:0] e0;
        e  = cyc + 32'd2;
        e0 = e + 32'd2;
        tx_q.push_back(e0 + 32'd16);
        tx_q.push_back(e0 + 32'd32);
        drive_at(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16);
        drive_at(e0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_at(e0 + 32'd40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        go_until(e0 + 32'd70);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL load_tx_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // div 64 -> os_div 4; TX and RX started together.
    task automatic test_rx_concurrent;
        logic [31:0] e;
        logic [31:0] e0;
        e  = cyc + 32'd2;
        e0 = e + 32'd2;
        tx_q.push_back(e0 + 32'd64);
        tx_q.push_back(e0 + 32'd128);
        for (int k = 1; k <= 42; k++) tk_q.push_back(e0 + 32'(4 * k));
        sm_q.push_back(e0 + 32'd32);
        sm_q.push_back(e0 + 32'd96);
        sm_q.push_back(e0 + 32'd160);
        drive_at(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd64);
        drive_at(e0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        drive_at(e0 + 32'd170, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        go_until(e0 + 32'd200);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL rx_concurrent_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // Rejected loads: below OSR while idle, and any load while TX runs.
    task automatic test_div_reject;
        logic [31:0] e;
        logic [31:0] e0;
        e  = cyc + 32'd2;
        e0 = e + 32'd3;
        er_q.push_back(e);
        er_q.push_back(e0 + 32'd10);
        tx_q.push_back(e0 + 32'd64);
        tx_q.push_back(e0 + 32'd128);
        drive_at(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5);
        drive_at(e0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_at(e0 + 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd32);
        drive_at(e0 + 32'd130, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        go_until(e0 + 32'd150);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL div_reject_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // div 16 (os_div 1). Start+done together while running restarts both
    // channels; RX sample phase realigns to the new start.
    task automatic test_restart;
        logic [31:0] e;
        logic [31:0] e0;
        logic [31:0] e1;
        e  = cyc + 32'd2;
        e0 = e + 32'd2;
        e1 = e0 + 32'd40;
        tx_q.push_back(e0 + 32'd16);
        tx_q.push_back(e0 + 32'd32);
        tx_q.push_back(e1 + 32'd16);
        tx_q.push_back(e1 + 32'd32);
        for (int k = 1; k <= 39; k++) tk_q.push_back(e0 + 32'(k));
        for (int k = 1; k <= 39; k++) tk_q.push_back(e1 + 32'(k));
        sm_q.push_back(e0 + 32'd8);
        sm_q.push_back(e0 + 32'd24);
        sm_q.push_back(e1 + 32'd8);
        sm_q.push_back(e1 + 32'd24);
        drive_at(e, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16);
        drive_at(e0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        drive_at(e1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
        drive_at(e1 + 32'd40, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        go_until(e1 + 32'd60);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL restart_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // Async reset in the middle of a strobe, then silence, then the reset
    // divisor is back in force.
    task automatic test_async_reset;
        logic [31:0] e0;
        logic [31:0] e;
        e0 = cyc + 32'd2;
        for (int k = 1; k <= 15; k++) tk_q.push_back(e0 + 32'(k));
        sm_q.push_back(e0 + 32'd8);
        drive_at(e0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        go_until(e0 + 32'd15);
        @(posedge clk);
        #1;
        total++;
        if ({tx_bps_clk, rx_os_tick} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset_strobe: got %b, required 11", {tx_bps_clk, rx_os_tick});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({tx_bps_clk, rx_os_tick, rx_sample, div_err} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_outputs: got %b, required 0000",
                     {tx_bps_clk, rx_os_tick, rx_sample, div_err});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        e = cyc + 32'd2;
        tx_q.push_back(e + 32'd5208);
        drive_at(e, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive_at(e + 32'd5210, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        go_until(e + 32'd5230);
        total++;
        if (tx_q.size() + tk_q.size() + sm_q.size() + er_q.size() != 0) begin
            bad++;
            $display("FAIL async_reset_drain: %0d pulses missing, required 0",
                     tx_q.size() + tk_q.size() + sm_q.size() + er_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_default_div();
        test_load_tx();
        test_rx_concurrent();
        test_div_reject();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
